id_stage_pipe: RTL and testbench

//  Parametrised decode stage: register file, control decode and immediate generation, behind an ID/EX output register.

---
 rtl/id_stage_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// Decode stage: register file, control decode and immediate generation behind an ID/EX register,
// with valid/ready handshakes, load-use bubble and branch flush. Define ID_WB_BYPASS_EN for WB->ID bypass.

package id_stage_pkg;
    typedef struct packed {
        logic [3:0] aluOp;
        logic       aluSrc;
        logic       branch;
        logic       jump;
        logic       auipc;
    } ex_ctrl_t;

    typedef struct packed {
        logic       memRead;
        logic       memWrite;
        logic [2:0] funct3;
    } mem_ctrl_t;

    typedef struct packed {
        logic       regWrite;
        logic [1:0] wbSel;
    } wb_ctrl_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;
endpackage

module id_control
    import id_stage_pkg::*;
(
    input  logic [31:0] i_instr,
    output ex_ctrl_t    o_ctrlEX,
    output mem_ctrl_t   o_ctrlMEM,
    output wb_ctrl_t    o_ctrlWB
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;

    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];
    assign f7b5   = i_instr[30];

    always_comb begin
        o_ctrlEX  = '0;
        o_ctrlMEM = '0;
        o_ctrlWB  = '0;
        case (opcode)
            OP_R: begin
                o_ctrlEX.aluOp    = {f7b5, funct3};
                o_ctrlWB.regWrite = 1'b1;
            end
            OP_IMM: begin
                // only the shift-right immediates carry an alternate-op bit
                o_ctrlEX.aluOp    = {(funct3 == 3'b101) && f7b5, funct3};
                o_ctrlEX.aluSrc   = 1'b1;
                o_ctrlWB.regWrite = 1'b1;
            end
            OP_LOAD: begin
                o_ctrlEX.aluSrc    = 1'b1;
                o_ctrlMEM.memRead  = 1'b1;
                o_ctrlMEM.funct3   = funct3;
                o_ctrlWB.regWrite  = 1'b1;
                o_ctrlWB.wbSel     = WB_MEM;
            end
            OP_STORE: begin
                o_ctrlEX.aluSrc    = 1'b1;
                o_ctrlMEM.memWrite = 1'b1;
                o_ctrlMEM.funct3   = funct3;
            end
            OP_BRANCH: begin
                o_ctrlEX.branch = 1'b1;
                o_ctrlEX.aluOp  = {1'b0, funct3};
            end
            OP_JAL: begin
                o_ctrlEX.jump     = 1'b1;
                o_ctrlWB.regWrite = 1'b1;
                o_ctrlWB.wbSel    = WB_PC4;
            end
            OP_JALR: begin
                o_ctrlEX.jump     = 1'b1;
                o_ctrlEX.aluSrc   = 1'b1;
                o_ctrlWB.regWrite = 1'b1;
                o_ctrlWB.wbSel    = WB_PC4;
            end
            OP_LUI: begin
                o_ctrlEX.aluSrc   = 1'b1;
                o_ctrlWB.regWrite = 1'b1;
                o_ctrlWB.wbSel    = WB_IMM;
            end
            OP_AUIPC: begin
                o_ctrlEX.auipc    = 1'b1;
                o_ctrlEX.aluSrc   = 1'b1;
                o_ctrlWB.regWrite = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

module id_immGen
    import id_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_immediate
);
    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (i_instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR:
                imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            OP_STORE:
                imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            OP_BRANCH:
                imm32 = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {i_instr[31:12], 12'b0};
            OP_JAL:
                imm32 = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
            default: ;
        endcase
    end

    assign o_immediate = XLEN'(signed'(imm32));
endmodule

module id_stage_pipe
    import id_stage_pkg::*;
#(
    parameter int  XLEN       = 32,
    parameter int  NREGS      = 32,
    localparam int REG_ADDR_W = $clog2(NREGS)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [31:0]           i_instr,
    input  logic [XLEN-1:0]       i_pc,
    input  logic                  i_flush,
    input  logic                  i_wrSig,
    input  logic [REG_ADDR_W-1:0] i_wrReg,
    input  logic [XLEN-1:0]       i_wrData,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [XLEN-1:0]       o_pc,
    output logic [XLEN-1:0]       o_rdData1,
    output logic [XLEN-1:0]       o_rdData2,
    output logic [XLEN-1:0]       o_immediate,
    output logic [REG_ADDR_W-1:0] o_rs1,
    output logic [REG_ADDR_W-1:0] o_rs2,
    output logic [REG_ADDR_W-1:0] o_rd,
    output ex_ctrl_t              o_ctrlEX,
    output mem_ctrl_t             o_ctrlMEM,
    output wb_ctrl_t              o_ctrlWB,
    output logic                  o_stall
);
    logic [4:0] rs1_f, rs2_f, rd_f;
    assign rs1_f = i_instr[19:15];
    assign rs2_f = i_instr[24:20];
    assign rd_f  = i_instr[11:7];

    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] rf_d [NREGS];
    logic            wr_en;

    assign wr_en = i_wrSig && (i_wrReg != '0) && (int'(i_wrReg) < NREGS);

    always_comb begin
        rf_d = rf_q;
        for (int k = 1; k < NREGS; k++)
            if (wr_en && int'(i_wrReg) == k) rf_d[k] = i_wrData;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < NREGS; k++) rf_q[k] <= '0;
        end else begin
            rf_q <= rf_d;
        end
    end

    // Index-compare read so out-of-range and x0 indices fall through to zero.
    logic [XLEN-1:0] rd1, rd2;
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int k = 1; k < NREGS; k++) begin
            if (int'(rs1_f) == k) rd1 = rf_q[k];
            if (int'(rs2_f) == k) rd2 = rf_q[k];
        end
`ifdef ID_WB_BYPASS_EN
        if (wr_en && int'(i_wrReg) == int'(rs1_f)) rd1 = i_wrData;
        if (wr_en && int'(i_wrReg) == int'(rs2_f)) rd2 = i_wrData;
`endif
    end

    ex_ctrl_t        dec_ex;
    mem_ctrl_t       dec_mem;
    wb_ctrl_t        dec_wb;
    logic [XLEN-1:0] dec_imm;

    id_control u_control (
        .i_instr   (i_instr),
        .o_ctrlEX  (dec_ex),
        .o_ctrlMEM (dec_mem),
        .o_ctrlWB  (dec_wb)
    );

    id_immGen #(.XLEN(XLEN)) u_immgen (
        .i_instr     (i_instr),
        .o_immediate (dec_imm)
    );

    logic                  valid_q, valid_d;
    logic [XLEN-1:0]       pc_q, pc_d;
    logic [XLEN-1:0]       rd1_q, rd1_d;
    logic [XLEN-1:0]       rd2_q, rd2_d;
    logic [XLEN-1:0]       imm_q, imm_d;
    logic [REG_ADDR_W-1:0] rs1_q, rs1_d;
    logic [REG_ADDR_W-1:0] rs2_q, rs2_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    ex_ctrl_t              ctrl_ex_q, ctrl_ex_d;
    mem_ctrl_t             ctrl_mem_q, ctrl_mem_d;
    wb_ctrl_t              ctrl_wb_q, ctrl_wb_d;

    logic       slot_free, hazard, accept;
    logic [4:0] rd_q5;

    assign rd_q5     = 5'(rd_q);
    assign slot_free = !valid_q || i_ready;
    assign hazard    = i_valid && valid_q && ctrl_mem_q.memRead && (rd_q != '0)
                       && ((rd_q5 == rs1_f) || (rd_q5 == rs2_f));
    assign o_ready   = slot_free && !hazard && !i_flush;
    assign accept    = i_valid && o_ready;
    assign o_stall   = hazard && slot_free;

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rd1_d      = rd1_q;
        rd2_d      = rd2_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        ctrl_ex_d  = ctrl_ex_q;
        ctrl_mem_d = ctrl_mem_q;
        ctrl_wb_d  = ctrl_wb_q;
        // Flush kills the slot even under backpressure; bubbles zero only the controls.
        if (i_flush || (slot_free && !accept)) begin
            valid_d    = 1'b0;
            ctrl_ex_d  = '0;
            ctrl_mem_d = '0;
            ctrl_wb_d  = '0;
        end else if (accept) begin
            valid_d    = 1'b1;
            pc_d       = i_pc;
            rd1_d      = rd1;
            rd2_d      = rd2;
            imm_d      = dec_imm;
            rs1_d      = REG_ADDR_W'(rs1_f);
            rs2_d      = REG_ADDR_W'(rs2_f);
            rd_d       = REG_ADDR_W'(rd_f);
            ctrl_ex_d  = dec_ex;
            ctrl_mem_d = dec_mem;
            ctrl_wb_d  = dec_wb;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            ctrl_ex_q  <= '0;
            ctrl_mem_q <= '0;
            ctrl_wb_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            ctrl_ex_q  <= ctrl_ex_d;
            ctrl_mem_q <= ctrl_mem_d;
            ctrl_wb_q  <= ctrl_wb_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_pc        = pc_q;
    assign o_rdData1   = rd1_q;
    assign o_rdData2   = rd2_q;
    assign o_immediate = imm_q;
    assign o_rs1       = rs1_q;
    assign o_rs2       = rs2_q;
    assign o_rd        = rd_q;
    assign o_ctrlEX    = ctrl_ex_q;
    assign o_ctrlMEM   = ctrl_mem_q;
    assign o_ctrlWB    = ctrl_wb_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: default 32-bit/32-reg instance plus a 64-bit/16-reg instance.
module tb_id_stage_pipe;
    import id_stage_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        i_valid, i_flush, i_wrSig, i_ready;
    logic [31:0] i_instr, i_pc, i_wrData;
    logic [4:0]  i_wrReg;
    logic        o_ready, o_valid, o_stall;
    logic [31:0] o_pc, o_rdData1, o_rdData2, o_immediate;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    ex_ctrl_t    o_ctrlEX;
    mem_ctrl_t   o_ctrlMEM;
    wb_ctrl_t    o_ctrlWB;

    id_stage_pipe u_dut (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_instr(i_instr), .i_pc(i_pc), .i_flush(i_flush),
        .i_wrSig(i_wrSig), .i_wrReg(i_wrReg), .i_wrData(i_wrData),
        .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc),
        .o_rdData1(o_rdData1), .o_rdData2(o_rdData2), .o_immediate(o_immediate),
        .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd),
        .o_ctrlEX(o_ctrlEX), .o_ctrlMEM(o_ctrlMEM), .o_ctrlWB(o_ctrlWB), .o_stall(o_stall)
    );

    logic        b_i_valid, b_i_wrSig;
    logic [31:0] b_i_instr;
    logic [63:0] b_i_pc, b_i_wrData;
    logic [3:0]  b_i_wrReg;
    logic        b_o_ready, b_o_valid, b_o_stall;
    logic [63:0] b_o_pc, b_o_rdData1, b_o_rdData2, b_o_immediate;
    logic [3:0]  b_o_rs1, b_o_rs2, b_o_rd;
    ex_ctrl_t    b_o_ctrlEX;
    mem_ctrl_t   b_o_ctrlMEM;
    wb_ctrl_t    b_o_ctrlWB;

    id_stage_pipe #(.XLEN(64), .NREGS(16)) u_dut_b (
        .i_clk(clk), .i_reset(rst), .i_valid(b_i_valid), .o_ready(b_o_ready),
        .i_instr(b_i_instr), .i_pc(b_i_pc), .i_flush(1'b0),
        .i_wrSig(b_i_wrSig), .i_wrReg(b_i_wrReg), .i_wrData(b_i_wrData),
        .o_valid(b_o_valid), .i_ready(1'b1), .o_pc(b_o_pc),
        .o_rdData1(b_o_rdData1), .o_rdData2(b_o_rdData2), .o_immediate(b_o_immediate),
        .o_rs1(b_o_rs1), .o_rs2(b_o_rs2), .o_rd(b_o_rd),
        .o_ctrlEX(b_o_ctrlEX), .o_ctrlMEM(b_o_ctrlMEM), .o_ctrlWB(b_o_ctrlWB), .o_stall(b_o_stall)
    );

    typedef struct packed {
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        mr, rw;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mdl[32];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic mr, input logic rw);
        exp_t e;
        e.pc = pc; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.mr = mr; e.rw = rw;
        return e;
    endfunction

    // Monitor: every transfer into EX is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && o_valid && i_ready) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("pc",       64'(o_pc),              64'(e.pc));
                chk("rdData1",  64'(o_rdData1),         64'(e.rd1));
                chk("rdData2",  64'(o_rdData2),         64'(e.rd2));
                chk("imm",      64'(o_immediate),       64'(e.imm));
                chk("rs1",      64'(o_rs1),             64'(e.rs1));
                chk("rs2",      64'(o_rs2),             64'(e.rs2));
                chk("rd",       64'(o_rd),              64'(e.rd));
                chk("memRead",  64'(o_ctrlMEM.memRead), 64'(e.mr));
                chk("regWrite", 64'(o_ctrlWB.regWrite), 64'(e.rw));
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the instruction.
    task automatic offer(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
        bit got = 0;
        i_valid = 1'b1; i_instr = instr; i_pc = pc;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (o_ready) begin
                got = 1;
                sbq.push_back(e);
            end
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        if (!got) chk("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        i_wrSig = 1'b1; i_wrReg = r; i_wrData = d;
        @(posedge clk); #1;
        i_wrSig = 1'b0;
        if (r != 0) mdl[r] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] i_lw, i_add8;
        rst = 1'b1;
        i_valid = 0; i_flush = 0; i_wrSig = 0; i_ready = 1;
        i_instr = '0; i_pc = '0; i_wrData = '0; i_wrReg = '0;
        b_i_valid = 0; b_i_wrSig = 0; b_i_instr = '0; b_i_pc = '0; b_i_wrData = '0; b_i_wrReg = '0;
        for (int k = 0; k < 32; k++) mdl[k] = '0;
        #3;
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_pc",    64'(o_pc), 64'(0));
        chk("rst_ctrl",  64'({o_ctrlEX, o_ctrlMEM, o_ctrlWB}), 64'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(o_ready), 64'(1));
        @(posedge clk); #1;

        // 64-bit / 16-register instance: index 20 must not alias x4, imm sign-extends to 64 bits
        b_i_wrSig = 1'b1; b_i_wrReg = 4'd4; b_i_wrData = 64'hABCD;
        @(posedge clk); #1;
        b_i_wrSig = 1'b0;
        b_i_valid = 1'b1; b_i_instr = enc_r(5'd1, 5'd20, 5'd4); b_i_pc = 64'h40;
        @(negedge clk);
        chk("b_ready", 64'(b_o_ready), 64'(1));
        @(posedge clk); #1;
        b_i_instr = enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, 7'b0010011);
        @(negedge clk);
        chk("b_valid",    64'(b_o_valid), 64'(1));
        chk("b_rdData1",  b_o_rdData1, 64'(0));
        chk("b_rdData2",  b_o_rdData2, 64'hABCD);
        @(posedge clk); #1;
        b_i_valid = 1'b0;
        @(negedge clk);
        chk("b_imm64", b_o_immediate, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;

        // write then read
        wb(5'd5, 32'hDEADBEEF);
        wb(5'd1, 32'h11);
        wb(5'd2, 32'h22);
        wb(5'd7, 32'h70);
        offer(enc_r(5'd6, 5'd5, 5'd0), 32'h100, mk(32'h100, mdl[5], 0, 0, 5, 0, 6, 0, 1));

        // load-use: one stall cycle, one bubble, then the dependent add goes in
        i_lw   = enc_i(12'd0, 5'd1, 3'b010, 5'd7, 7'b0000011);
        i_add8 = enc_r(5'd8, 5'd7, 5'd2);
        offer(i_lw, 32'h104, mk(32'h104, mdl[1], 0, 0, 1, 0, 7, 1, 1));
        i_valid = 1'b1; i_instr = i_add8; i_pc = 32'h108;
        @(negedge clk);
        chk("lu_stall", 64'(o_stall), 64'(1));
        chk("lu_ready", 64'(o_ready), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("lu_bubble", 64'(o_valid), 64'(0));
        chk("lu_stall1", 64'(o_stall), 64'(0));
        chk("lu_ready1", 64'(o_ready), 64'(1));
        sbq.push_back(mk(32'h108, mdl[7], mdl[2], 0, 7, 2, 8, 0, 1));
        @(posedge clk); #1;
        i_valid = 1'b0;

        // backpressure, then a flush while EX is still stalled
        offer(enc_i(12'hFFF, 5'd0, 3'b000, 5'd10, 7'b0010011), 32'h10C,
              mk(32'h10C, 0, 0, 32'hFFFFFFFF, 0, 31, 10, 0, 1));
        i_ready = 1'b0;
        i_valid = 1'b1; i_instr = enc_r(5'd9, 5'd1, 5'd2); i_pc = 32'h110;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_valid", 64'(o_valid), 64'(1));
            chk("bp_ready", 64'(o_ready), 64'(0));
            chk("bp_pc",    64'(o_pc), 64'h10C);
            @(posedge clk); #1;
        end
        i_flush = 1'b1;
        @(negedge clk);
        chk("fl_ready", 64'(o_ready), 64'(0));
        @(posedge clk); #1;
        i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        @(negedge clk);
        chk("fl_valid", 64'(o_valid), 64'(0));
        sbq.delete(sbq.size() - 1);
        @(posedge clk); #1;

        // S-type immediate
        offer(enc_s(12'hFFC, 5'd2, 5'd1), 32'h114, mk(32'h114, mdl[1], mdl[2], 32'hFFFFFFFC, 1, 2, 28, 0, 0));

        // x0 stays zero; same-cycle write/read of x9
        wb(5'd0, 32'h1234);
        offer(enc_r(5'd11, 5'd0, 5'd0), 32'h118, mk(32'h118, 0, 0, 0, 0, 0, 11, 0, 1));
        i_wrSig = 1'b1; i_wrReg = 5'd9; i_wrData = 32'h55;
`ifdef ID_WB_BYPASS_EN
        offer(enc_r(5'd12, 5'd9, 5'd0), 32'h11C, mk(32'h11C, 32'h55, 0, 0, 9, 0, 12, 0, 1));
`else
        offer(enc_r(5'd12, 5'd9, 5'd0), 32'h11C, mk(32'h11C, 32'h0, 0, 0, 9, 0, 12, 0, 1));
`endif
        i_wrSig = 1'b0;
        mdl[9] = 32'h55;
        offer(enc_r(5'd13, 5'd9, 5'd9), 32'h120, mk(32'h120, mdl[9], mdl[9], 0, 9, 9, 13, 0, 1));

        // reset mid-stream with a live instruction held in ID/EX
        offer(enc_r(5'd14, 5'd5, 5'd0), 32'h200, mk(32'h200, mdl[5], 0, 0, 5, 0, 14, 0, 1));
        i_ready = 1'b0;
        #1;
        chk("mr_live", 64'(o_valid), 64'(1));
        rst = 1'b1;
        #1;
        chk("mr_valid", 64'(o_valid), 64'(0));
        chk("mr_pc",    64'(o_pc), 64'(0));
        chk("mr_rd1",   64'(o_rdData1), 64'(0));
        chk("mr_ctrl",  64'({o_ctrlEX, o_ctrlMEM, o_ctrlWB}), 64'(0));
        sbq.delete(sbq.size() - 1);
        @(posedge clk); #1;
        rst = 1'b0; i_ready = 1'b1;
        for (int k = 0; k < 32; k++) mdl[k] = '0;
        @(negedge clk);
        chk("mr_ready", 64'(o_ready), 64'(1));
        @(posedge clk); #1;
        offer(enc_r(5'd15, 5'd5, 5'd0), 32'h204, mk(32'h204, mdl[5], 0, 0, 5, 0, 15, 0, 1));

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sbq.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
